// File: rtl/cp_insert_ctrl.sv
// Cyclic-prefix insertion controller.
// Drives an external 2*NFFT-deep sample RAM as a ping-pong buffer. The writer
// fills one bank while the reader replays the other as CP (last NCP samples)
// followed by the full body. The controller never sees the sample data.
module cp_insert_ctrl #(
    parameter int NFFT = 64,
    parameter int NCP  = 16,
    parameter int B    = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_stb,
    output logic         o_in_rdy,
    output logic         o_wr_ena,
    output logic [B:0]   o_wr_adr,
    output logic         o_rd_ena,
    output logic [B:0]   o_rd_adr,
    output logic         o_out_stb,
    output logic         o_out_sof,
    output logic         o_out_eof
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam logic [B-1:0] LP_CNT_LAST = B'(NFFT - 1);
    localparam logic [B-1:0] LP_CP_FIRST = B'(NFFT - NCP);

    logic         r_wr_bank;
    logic [B-1:0] r_wr_cnt;
    logic [1:0]   r_bank_full;
    logic         r_rd_bank;
    logic [B-1:0] r_rd_cnt;
    state_t       r_state;
    logic         r_out_stb;
    logic         r_out_sof;
    logic         r_out_eof;

    logic         w_wr_ena;
    logic         w_wr_last;
    logic         w_rd_active;
    logic         w_cp_first;
    logic         w_body_last;
    logic [1:0]   w_full_set;
    logic [1:0]   w_full_clr;

    // Handshake, strobes and addresses; reset forces the interface quiet.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        w_full_set  = '0;
        w_full_clr  = '0;
        w_rd_active = (r_state != S_IDLE);
        w_cp_first  = (r_state == S_CP) && (r_rd_cnt == LP_CP_FIRST);
        w_body_last = (r_state == S_BODY) && (r_rd_cnt == LP_CNT_LAST);
        w_wr_ena    = i_in_stb & ~r_bank_full[r_wr_bank] & ~i_rst;
        w_wr_last   = w_wr_ena && (r_wr_cnt == LP_CNT_LAST);
        if (w_wr_last)   w_full_set[r_wr_bank] = 1'b1;
        if (w_body_last) w_full_clr[r_rd_bank] = 1'b1;

        o_in_rdy = i_rst | ~r_bank_full[r_wr_bank];
        o_wr_ena = w_wr_ena;
        o_wr_adr = i_rst ? '0 : {r_wr_bank, r_wr_cnt};
        o_rd_ena = w_rd_active & ~i_rst;
        o_rd_adr = o_rd_ena ? {r_rd_bank, r_rd_cnt} : '0;
    end

    // Writer: fill the current bank sample by sample, then hand it over.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every block
        // sees the pre-edge values regardless of evaluation order.
        if (i_rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (w_wr_ena) begin
            if (w_wr_last) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt  <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Bank ownership: writer sets and reader clears, always on opposite banks.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_bank_full <= 2'b00;
        else       r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
    end

    // Reader FSM: replay CP then body of each full bank, with registered framing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            r_out_stb <= 1'b0;
            r_out_sof <= 1'b0;
            r_out_eof <= 1'b0;
        end else begin
            r_out_stb <= w_rd_active;
            r_out_sof <= w_cp_first;
            r_out_eof <= w_body_last;
            case (r_state)
                S_IDLE: begin
                    if (r_bank_full[r_rd_bank]) begin
                        r_state  <= S_CP;
                        r_rd_cnt <= LP_CP_FIRST;
                    end
                end
                S_CP: begin
                    if (r_rd_cnt == LP_CNT_LAST) begin
                        r_rd_cnt <= '0;
                        r_state  <= S_BODY;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                S_BODY: begin
                    if (w_body_last) begin
                        r_rd_bank <= ~r_rd_bank;
                        // Chain straight into the next symbol when it is ready.
                        if (r_bank_full[~r_rd_bank]) begin
                            r_state  <= S_CP;
                            r_rd_cnt <= LP_CP_FIRST;
                        end else begin
                            r_state  <= S_IDLE;
                            r_rd_cnt <= '0;
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_cnt <= '0;
                end
            endcase
        end
    end

    assign o_out_stb = r_out_stb;
    assign o_out_sof = r_out_sof;
    assign o_out_eof = r_out_eof;

endmodule

// File: tb/tb_cp_insert_ctrl.sv
// Bench for cp_insert_ctrl (NFFT=64, NCP=16). The reference model tracks
// samples accepted and symbols fully read out, and derives every expected
// strobe and address from those counts.
module tb_cp_insert_ctrl;

    localparam int NFFT = 64;
    localparam int NCP  = 16;
    localparam int B    = 6;
    localparam int SYM  = NFFT + NCP;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         in_stb = 1'b0;
    logic         o_in_rdy, o_wr_ena, o_rd_ena, o_out_stb, o_out_sof, o_out_eof;
    logic [B:0]   o_wr_adr, o_rd_adr;

    always #5 clk = ~clk;

    cp_insert_ctrl #(.NFFT(NFFT), .NCP(NCP), .B(B)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_in_stb  (in_stb),
        .o_in_rdy  (o_in_rdy),
        .o_wr_ena  (o_wr_ena),
        .o_wr_adr  (o_wr_adr),
        .o_rd_ena  (o_rd_ena),
        .o_rd_adr  (o_rd_adr),
        .o_out_stb (o_out_stb),
        .o_out_sof (o_out_sof),
        .o_out_eof (o_out_eof)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int n_acc     = 0;   // samples accepted since reset
    int r_done    = 0;   // symbols completely read since reset
    bit rd_active = 0;   // a symbol is being read this cycle
    int rd_pos    = 0;   // position 0..SYM-1 within that symbol
    bit p_stb = 0, p_sof = 0, p_eof = 0;

    // Directed timing capture
    bit track = 0;
    int cyc = 0;
    int first_rd = -1, first_sof = -1, first_eof = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (vector %0d)", tag, obs, exp, n_vec);
        end
    endtask

    task automatic step(input bit r, input bit s);
        int w_syms, e_rdy, e_wen, e_wadr, e_ren, e_radr, e_sof, e_eof;
        i_rst  = r;
        in_stb = s;
        #1;
        w_syms = n_acc / NFFT;
        if (r) begin
            e_rdy = 1; e_wen = 0; e_wadr = 0; e_ren = 0; e_radr = 0;
        end else begin
            e_rdy  = (w_syms - r_done < 2) ? 1 : 0;
            e_wen  = (s && e_rdy == 1) ? 1 : 0;
            e_wadr = n_acc % (2 * NFFT);
            e_ren  = rd_active ? 1 : 0;
            e_radr = 0;
            if (rd_active)
                e_radr = (r_done % 2) * NFFT + ((rd_pos < NCP) ? (NFFT - NCP + rd_pos) : (rd_pos - NCP));
        end
        chk("in_rdy",  32'(o_in_rdy),  e_rdy);
        chk("wr_ena",  32'(o_wr_ena),  e_wen);
        chk("wr_adr",  32'(o_wr_adr),  e_wadr);
        chk("rd_ena",  32'(o_rd_ena),  e_ren);
        chk("rd_adr",  32'(o_rd_adr),  e_radr);
        chk("out_stb", 32'(o_out_stb), 32'(p_stb));
        chk("out_sof", 32'(o_out_sof), 32'(p_sof));
        chk("out_eof", 32'(o_out_eof), 32'(p_eof));
        if (track) begin
            if (o_rd_ena  && first_rd  < 0) first_rd  = cyc;
            if (o_out_sof && first_sof < 0) first_sof = cyc;
            if (o_out_eof && first_eof < 0) first_eof = cyc;
        end
        n_vec++;

        e_sof = (!r && rd_active && rd_pos == 0) ? 1 : 0;
        e_eof = (!r && rd_active && rd_pos == SYM - 1) ? 1 : 0;
        @(posedge clk);
        #1;
        if (r) begin
            n_acc = 0; r_done = 0; rd_active = 0; rd_pos = 0;
            p_stb = 0; p_sof = 0; p_eof = 0;
        end else begin
            p_stb = (e_ren == 1);
            p_sof = (e_sof == 1);
            p_eof = (e_eof == 1);
            if (!rd_active) begin
                // Start one cycle after a full symbol is visible while idle.
                if (w_syms > r_done) begin
                    rd_active = 1;
                    rd_pos    = 0;
                end
            end else if (rd_pos == SYM - 1) begin
                // Chain directly if the following symbol was already complete.
                if (w_syms >= r_done + 2) rd_pos = 0;
                else                      rd_active = 0;
                r_done++;
            end else begin
                rd_pos++;
            end
            if (e_wen == 1) n_acc++;
        end
        cyc++;
    endtask

    initial begin
        bit found;
        @(posedge clk);
        #1;

        // Reset: two cycles, then quiet interface with in_rdy high
        step(1, 0);
        step(1, 0);
        chk("rst_in_rdy", 32'(o_in_rdy), 1);
        chk("rst_rd_ena", 32'(o_rd_ena), 0);
        chk("rst_out_stb", 32'(o_out_stb), 0);

        // One symbol written in cycles 0..63, then idle: exact read timing
        track = 1; cyc = 0;
        for (int i = 0; i < 64; i++) step(0, 1);
        for (int i = 0; i < 100; i++) step(0, 0);
        track = 0;
        chk("first_rd_cycle",  first_rd,  65);
        chk("first_sof_cycle", first_sof, 66);
        chk("first_eof_cycle", first_eof, 145);
        // Second and third symbols: bank 1, then bank 0 reused
        for (int i = 0; i < 128; i++) step(0, 1);
        for (int i = 0; i < 200; i++) step(0, 0);

        // in_stb held high from reset: backpressure and continuous reads
        step(1, 0);
        for (int i = 0; i < 500; i++) step(0, 1);

        // in_stb every other cycle: ready never drops, bursts of SYM reads
        step(1, 0);
        for (int i = 0; i < 500; i++) step(0, (i % 2) == 0);

        // Randomised input pacing with occasional resets
        step(1, 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(299) == 0, $urandom_range(3) != 0);

        // Reset during BODY at rd_adr 20, with in_stb asserted alongside
        step(1, 0);
        for (int i = 0; i < 64; i++) step(0, 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (o_rd_ena && o_rd_adr == 7'd20) found = 1;
            else step(0, 0);
        end
        chk("body_adr20_reached", 32'(found), 1);
        step(1, 1);
        chk("post_rst_rd_ena", 32'(o_rd_ena), 0);
        chk("post_rst_wr_adr", 32'(o_wr_adr), 0);
        chk("post_rst_in_rdy", 32'(o_in_rdy), 1);
        for (int i = 0; i < 64; i++) step(0, 1);
        for (int i = 0; i < 100; i++) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
